// File: rtl/sr_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : sr_seq_pkg                                                      |
// | Purpose  : Mode encoding and Gray/binary conversion helpers shared by the  |
// |            SR-cell sequence counter.                                       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package sr_seq_pkg;

   typedef enum logic [1:0] {
      MODE_UP   = 2'b00,
      MODE_DN   = 2'b01,
      MODE_GRAY = 2'b10,
      MODE_TBL  = 2'b11
   } mode_e;

   // Helpers work on a fixed wide word; callers zero-extend and truncate.
   localparam int GW = 32;

   function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at and above it.
   function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
      logic [GW-1:0] b;
      b[GW-1] = g[GW-1];
      for (int i = GW-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sr_cell.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sr_cell                                                         |
// | Purpose  : Single clocked SR storage bit with asynchronous active-low      |
// |            reset to a per-bit value.                                       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sr_cell (
   input  logic clk,
   input  logic clear_n,
   input  logic s,
   input  logic r,
   input  logic rst_val,
   output logic q
);

   // Set, reset or hold; the driver guarantees s and r are never both high.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         q <= rst_val;
      end else begin
         case ({s, r})
            2'b10:   q <= 1'b1;
            2'b01:   q <= 1'b0;
            default: q <= q;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/sr_seq_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sr_seq_counter                                                  |
// | Purpose  : Multi-mode sequence counter (binary up/down, Gray up, or a      |
// |            programmable table) whose state bits live in SR cells.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sr_seq_counter
   import sr_seq_pkg::*;
#(
   parameter int               WIDTH     = 3,
   parameter int               DEPTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(1),
   localparam int              IW        = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             tbl_we,
   input  logic [IW-1:0]    tbl_addr,
   input  logic [WIDTH-1:0] tbl_wdata,
   input  logic [IW-1:0]    seq_last,
   output logic [WIDTH-1:0] q,
   output logic [IW-1:0]    idx,
   output logic             tc
);

   logic [WIDTH-1:0] tbl [DEPTH];
   logic [WIDTH-1:0] q_next;
   logic [IW-1:0]    idx_next;
   logic [IW-1:0]    step_idx;
   logic [IW-1:0]    load_raw;
   logic [IW-1:0]    load_idx;
   logic [WIDTH-1:0] gray_bin_inc;
   logic [WIDTH-1:0] gray_next;
   logic [WIDTH-1:0] s_vec;
   logic [WIDTH-1:0] r_vec;
   logic             terminal;
   mode_e            mode_q;

   assign mode_q = mode_e'(mode);

   // Table index arithmetic: wrap at (or past) seq_last, clamp loads beyond it to 0.
   assign step_idx = (idx >= seq_last) ? '0 : idx + IW'(1);
   assign load_raw = IW'(load_val);
   assign load_idx = (load_raw > seq_last) ? '0 : load_raw;

   // Gray successor: decode, increment, re-encode; upper helper bits are zero.
   assign gray_bin_inc = WIDTH'(gray2bin(GW'(q))) + WIDTH'(1);
   assign gray_next    = WIDTH'(bin2gray(GW'(gray_bin_inc)));

   // Next-state selection with load > en > hold priority.
   always_comb begin
      q_next   = q;
      idx_next = idx;
      if (load) begin
         if (mode_q == MODE_TBL) begin
            idx_next = load_idx;
            q_next   = tbl[load_idx];
         end else begin
            q_next = load_val;
         end
      end else if (en) begin
         case (mode_q)
            MODE_UP:   q_next = q + WIDTH'(1);
            MODE_DN:   q_next = q - WIDTH'(1);
            MODE_GRAY: q_next = gray_next;
            MODE_TBL: begin
               idx_next = step_idx;
               q_next   = tbl[step_idx];
            end
            default:   q_next = q;
         endcase
      end
   end

   // Only flip bits that change, so set and reset are mutually exclusive.
   assign s_vec = q_next & ~q;
   assign r_vec = ~q_next & q;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bits
         sr_cell u_cell (
            .clk     (clk),
            .clear_n (clear_n),
            .s       (s_vec[i]),
            .r       (r_vec[i]),
            .rst_val (RESET_VAL[i]),
            .q       (q[i])
         );
      end
   endgenerate

   // Table index register.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         idx <= '0;
      end else begin
         idx <= idx_next;
      end
   end

   // Sequence table: identity map on reset; reads above see the pre-write value.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            tbl[i] <= WIDTH'(i);
         end
      end else if (tbl_we) begin
         tbl[tbl_addr] <= tbl_wdata;
      end
   end

   // Terminal-state decode from registered state, gated by en.
   always_comb begin
      terminal = 1'b0;
      case (mode_q)
         MODE_UP:   terminal = (q == {WIDTH{1'b1}});
         MODE_DN:   terminal = (q == '0);
         MODE_GRAY: terminal = (q == (WIDTH'(1) << (WIDTH-1)));
         MODE_TBL:  terminal = (idx >= seq_last);
         default:   terminal = 1'b0;
      endcase
   end

   assign tc = en & terminal;

endmodule
`default_nettype wire

// File: tb/tb_sr_seq_counter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sr_seq_counter                                               |
// | Purpose  : Self-checking bench for sr_seq_counter (WIDTH=3, DEPTH=8).      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_sr_seq_counter;

   logic       clk = 1'b0;
   logic       clear_n = 1'b0;
   logic       en = 1'b0;
   logic [1:0] mode = 2'd0;
   logic       load = 1'b0;
   logic [2:0] load_val = 3'd0;
   logic       tbl_we = 1'b0;
   logic [2:0] tbl_addr = 3'd0;
   logic [2:0] tbl_wdata = 3'd0;
   logic [2:0] seq_last = 3'd7;
   logic [2:0] q;
   logic [2:0] idx;
   logic       tc;

   int n_checks = 0;
   int n_fail   = 0;
   int sr_bad   = 0;

   // Reference model state
   int mq;
   int midx;
   int mtbl [8];

   sr_seq_counter #(.WIDTH(3), .DEPTH(8), .RESET_VAL(3'b001)) dut (
      .clk       (clk),
      .clear_n   (clear_n),
      .en        (en),
      .mode      (mode),
      .load      (load),
      .load_val  (load_val),
      .tbl_we    (tbl_we),
      .tbl_addr  (tbl_addr),
      .tbl_wdata (tbl_wdata),
      .seq_last  (seq_last),
      .q         (q),
      .idx       (idx),
      .tc        (tc)
   );

   always #5 clk = ~clk;

   // Simultaneous set and reset on any cell is illegal.
   always @(negedge clk) begin
      if ((dut.s_vec & dut.r_vec) != 3'd0) sr_bad++;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   function automatic int gray_succ(input int g);
      int b;
      b = 0;
      for (int k = 0; k < 8; k++) if ((k ^ (k >> 1)) == g) b = k;
      b = (b + 1) % 8;
      return b ^ (b >> 1);
   endfunction

   function automatic logic m_tc();
      if (!en) return 1'b0;
      case (mode)
         2'd0:    return mq == 7;
         2'd1:    return mq == 0;
         2'd2:    return mq == 4;
         default: return midx >= int'(seq_last);
      endcase
   endfunction

   task automatic model_reset();
      mq = 1;
      midx = 0;
      for (int k = 0; k < 8; k++) mtbl[k] = k;
   endtask

   task automatic apply(input logic e, input logic [1:0] m, input logic ld, input logic [2:0] lv,
                        input logic we, input logic [2:0] wa, input logic [2:0] wd, input logic [2:0] sl);
      @(negedge clk);
      en = e; mode = m; load = ld; load_val = lv;
      tbl_we = we; tbl_addr = wa; tbl_wdata = wd; seq_last = sl;
      #1;
   endtask

   // Advance one rising edge, moving the model by the same rules.
   task automatic tick();
      int nq, ni, li, sl;
      logic we;
      int wa, wd;
      nq = mq; ni = midx; sl = int'(seq_last);
      we = tbl_we; wa = int'(tbl_addr); wd = int'(tbl_wdata);
      if (load) begin
         if (mode == 2'd3) begin
            li = int'(load_val);
            if (li > sl) li = 0;
            ni = li;
            nq = mtbl[li];
         end else begin
            nq = int'(load_val);
         end
      end else if (en) begin
         case (mode)
            2'd0: nq = (mq + 1) % 8;
            2'd1: nq = (mq + 7) % 8;
            2'd2: nq = gray_succ(mq);
            default: begin
               ni = (midx >= sl) ? 0 : midx + 1;
               nq = mtbl[ni];
            end
         endcase
      end
      @(posedge clk);
      if (we) mtbl[wa] = wd;
      mq = nq;
      midx = ni;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      en = 0; load = 0; tbl_we = 0; mode = 0; seq_last = 7;
      clear_n = 1'b0;
      model_reset();
      #2;
      clear_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (q !== 3'd1) begin n_fail++; $display("FAIL reset_q: got %0d, required 1", q); end
      n_checks++; if (idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx: got %0d, required 0", idx); end
      n_checks++; if (tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc: got %0d, required 0", tc); end
   endtask

   task automatic test_bin_up();
      int exp_q [8] = '{2, 3, 4, 5, 6, 7, 0, 1};
      int prev;
      prev = 1;
      for (int i = 0; i < 8; i++) begin
         apply(1, 0, 0, 0, 0, 0, 0, 7);
         n_checks++;
         if (tc !== (prev == 7)) begin n_fail++; $display("FAIL up_tc step %0d: got %0d, required %0d", i, tc, prev == 7); end
         tick();
         n_checks++;
         if (int'(q) !== exp_q[i]) begin n_fail++; $display("FAIL up_q step %0d: got %0d, required %0d", i, q, exp_q[i]); end
         prev = exp_q[i];
      end
   endtask

   task automatic test_bin_down();
      apply(0, 1, 1, 0, 0, 0, 0, 7);
      tick();
      n_checks++; if (q !== 3'd0) begin n_fail++; $display("FAIL dn_load: got %0d, required 0", q); end
      apply(1, 1, 0, 0, 0, 0, 0, 7);
      n_checks++; if (tc !== 1'b1) begin n_fail++; $display("FAIL dn_tc_at0: got %0d, required 1", tc); end
      tick();
      n_checks++; if (q !== 3'd7) begin n_fail++; $display("FAIL dn_wrap: got %0d, required 7", q); end
      apply(1, 1, 0, 0, 0, 0, 0, 7);
      n_checks++; if (tc !== 1'b0) begin n_fail++; $display("FAIL dn_tc_at7: got %0d, required 0", tc); end
      tick();
      n_checks++; if (q !== 3'd6) begin n_fail++; $display("FAIL dn_step: got %0d, required 6", q); end
      apply(1, 1, 1, 5, 0, 0, 0, 7);
      tick();
      n_checks++; if (q !== 3'd5) begin n_fail++; $display("FAIL load_over_en: got %0d, required 5", q); end
   endtask

   task automatic test_gray();
      int exp_q [8] = '{3, 2, 6, 7, 5, 4, 0, 1};
      int prev;
      do_reset();
      prev = 1;
      for (int i = 0; i < 8; i++) begin
         apply(1, 2, 0, 0, 0, 0, 0, 7);
         n_checks++;
         if (tc !== (prev == 4)) begin n_fail++; $display("FAIL gray_tc step %0d: got %0d, required %0d", i, tc, prev == 4); end
         tick();
         n_checks++;
         if (int'(q) !== exp_q[i]) begin n_fail++; $display("FAIL gray_q step %0d: got %0d, required %0d", i, q, exp_q[i]); end
         n_checks++;
         if ($countones(q ^ 3'(prev)) != 1) begin n_fail++; $display("FAIL gray_1bit step %0d: got %0d->%0d, required one bit change", i, prev, q); end
         prev = exp_q[i];
      end
   endtask

   task automatic test_table();
      int wv [4]    = '{5, 2, 7, 0};
      int exp_q [4] = '{2, 7, 0, 5};
      int exp_i [4] = '{1, 2, 3, 0};
      for (int i = 0; i < 4; i++) begin
         apply(0, 3, 0, 0, 1, 3'(i), 3'(wv[i]), 3);
         tick();
      end
      apply(0, 3, 1, 0, 0, 0, 0, 3);
      tick();
      n_checks++; if (q !== 3'd5 || idx !== 3'd0) begin n_fail++; $display("FAIL tbl_load: got q=%0d idx=%0d, required q=5 idx=0", q, idx); end
      for (int i = 0; i < 4; i++) begin
         apply(1, 3, 0, 0, 0, 0, 0, 3);
         n_checks++;
         if (tc !== (i == 3)) begin n_fail++; $display("FAIL tbl_tc step %0d: got %0d, required %0d", i, tc, i == 3); end
         tick();
         n_checks++;
         if (int'(q) !== exp_q[i] || int'(idx) !== exp_i[i]) begin
            n_fail++; $display("FAIL tbl_step %0d: got q=%0d idx=%0d, required q=%0d idx=%0d", i, q, idx, exp_q[i], exp_i[i]);
         end
      end
      // Write entry 1 on the cycle that steps into it: old value first.
      apply(1, 3, 0, 0, 1, 1, 6, 3);
      tick();
      n_checks++; if (q !== 3'd2) begin n_fail++; $display("FAIL tbl_rw_old: got %0d, required 2", q); end
      for (int i = 0; i < 3; i++) begin
         apply(1, 3, 0, 0, 0, 0, 0, 3);
         tick();
      end
      apply(1, 3, 0, 0, 0, 0, 0, 3);
      tick();
      n_checks++; if (q !== 3'd6 || idx !== 3'd1) begin n_fail++; $display("FAIL tbl_rw_new: got q=%0d idx=%0d, required q=6 idx=1", q, idx); end
   endtask

   task automatic test_seq_last();
      apply(1, 3, 0, 0, 0, 0, 0, 3);
      tick();
      apply(1, 3, 0, 0, 0, 0, 0, 3);
      tick();
      n_checks++; if (idx !== 3'd3) begin n_fail++; $display("FAIL sl_setup: got idx=%0d, required 3", idx); end
      apply(1, 3, 0, 0, 0, 0, 0, 1);
      n_checks++; if (tc !== 1'b1) begin n_fail++; $display("FAIL sl_shrink_tc: got %0d, required 1", tc); end
      tick();
      n_checks++; if (q !== 3'd5 || idx !== 3'd0) begin n_fail++; $display("FAIL sl_shrink: got q=%0d idx=%0d, required q=5 idx=0", q, idx); end
      apply(1, 3, 0, 0, 0, 0, 0, 1);
      tick();
      apply(0, 3, 1, 6, 0, 0, 0, 1);
      tick();
      n_checks++; if (q !== 3'd5 || idx !== 3'd0) begin n_fail++; $display("FAIL load_clamp: got q=%0d idx=%0d, required q=5 idx=0", q, idx); end
      for (int i = 0; i < 2; i++) begin
         apply(1, 3, 0, 0, 0, 0, 0, 0);
         n_checks++; if (tc !== 1'b1) begin n_fail++; $display("FAIL sl0_tc %0d: got %0d, required 1", i, tc); end
         tick();
         n_checks++; if (q !== 3'd5 || idx !== 3'd0) begin n_fail++; $display("FAIL sl0_step %0d: got q=%0d idx=%0d, required q=5 idx=0", i, q, idx); end
      end
      apply(0, 3, 0, 0, 0, 0, 0, 0);
      n_checks++; if (tc !== 1'b0) begin n_fail++; $display("FAIL sl0_tc_noen: got %0d, required 0", tc); end
   endtask

   task automatic test_random();
      logic [2:0] sl;
      logic       ld;
      sl = 3'd7;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) sl = 3'($urandom_range(0, 7));
         ld = ($urandom_range(0, 7) == 0);
         apply(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), ld, 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), sl);
         n_checks++;
         if (tc !== m_tc()) begin n_fail++; $display("FAIL rand_tc cyc %0d: got %0d, required %0d", i, tc, m_tc()); end
         tick();
         n_checks++;
         if (int'(q) !== mq || int'(idx) !== midx) begin
            n_fail++; $display("FAIL rand_state cyc %0d: got q=%0d idx=%0d, required q=%0d idx=%0d", i, q, idx, mq, midx);
         end
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         apply(1, 0, 0, 0, 0, 0, 0, 7);
         tick();
      end
      // Drop reset between edges and look before the next edge.
      apply(1, 0, 0, 0, 0, 0, 0, 7);
      clear_n = 1'b0;
      model_reset();
      #1;
      n_checks++; if (q !== 3'd1 || idx !== 3'd0) begin n_fail++; $display("FAIL async_reset: got q=%0d idx=%0d, required q=1 idx=0", q, idx); end
      @(negedge clk);
      clear_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         apply(0, 3, 1, 3'(i), 0, 0, 0, 7);
         tick();
         n_checks++;
         if (int'(q) !== i) begin n_fail++; $display("FAIL tbl_identity %0d: got %0d, required %0d", i, q, i); end
      end
      n_checks++; if (sr_bad !== 0) begin n_fail++; $display("FAIL sr_exclusive: got %0d violations, required 0", sr_bad); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_bin_up();
      test_bin_down();
      test_gray();
      test_table();
      test_seq_last();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
